pipe_ctrl: RTL and testbench

Central stall/flush sequencer for the five-stage pipeline. It drives the `stall` and `refresh` inputs of all four segment registers (if_id, id_ex, ex_mem, mem_wb) and the PC hold. It resolves five sources by fixed priority: exception/eret, data-memory wait, divider busy, load-use hazard and instruction-memory wait. It also owns the multi-cycle divider countdown and the discard of an in-flight instruction fetch after a redirect.

---
 rtl/pipe_ctrl.sv | 138 +++++++++++++
 tb/tb_pipe_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline, with divider countdown and fetch discard.
// Optional PIPE_CTRL_PERF_EN adds 32-bit stall and flush event counters.
module pipe_ctrl #(
    parameter int DIV_CYCLES = 33
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_exc,
    input  logic        mem_eret,
    input  logic        data_wait,
    input  logic        ex_div_start,
    input  logic        id_load_use,
    input  logic        inst_wait,
    input  logic        inst_data_ok,
    output logic        stall_pc,
    output logic        stall_if_id,
    output logic        stall_id_ex,
    output logic        stall_ex_mem,
    output logic        stall_mem_wb,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        flush_ex_mem,
    output logic        flush_mem_wb,
    output logic        ex_div_done,
    output logic        if_discard,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
);

    typedef enum logic {
        RUN = 1'b0,
        DIV = 1'b1
    } st_e;

    localparam logic [7:0] DCNT_INIT = 8'(DIV_CYCLES - 1);

    st_e        st_q, st_d;
    logic [7:0] dcnt_q, dcnt_d;
    logic       disc_q, disc_d;

    logic       exc;
    logic       div_start;
    logic       div_last;
    logic       div_hold;
    logic [4:0] stall_v;
    logic [3:0] flush_v;

    always_comb begin
        exc       = mem_exc | mem_eret;
        div_start = (st_q == RUN) && ex_div_start && !exc && !data_wait;
        div_last  = (st_q == DIV) && (dcnt_q == 8'd1);
        // A start holds the pipe in its own cycle, so latency counts from it.
        div_hold  = ((st_q == DIV) && !div_last) || div_start;

        stall_v = 5'b00000;
        flush_v = 4'b0000;
        if (exc) begin
            flush_v = 4'b1111;
        end else if (data_wait) begin
            stall_v = 5'b11110;
            flush_v = 4'b0001;
        end else if (div_hold) begin
            stall_v = 5'b11100;
            flush_v = 4'b0010;
        end else if (id_load_use || inst_wait || disc_q) begin
            stall_v = 5'b11000;
            flush_v = 4'b0100;
        end
        if (!resetn) begin
            stall_v = 5'b00000;
            flush_v = 4'b0000;
        end
    end

    assign {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb} = stall_v;
    assign {flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb} = flush_v;
    assign ex_div_done = resetn & div_last & ~exc;
    assign if_discard  = resetn & disc_q & inst_data_ok;

    always_comb begin
        st_d   = st_q;
        dcnt_d = dcnt_q;
        disc_d = disc_q & ~inst_data_ok;
        if (exc) begin
            st_d   = RUN;
            dcnt_d = 8'd0;
            // A response landing with the redirect is not stale.
            disc_d = (disc_q | inst_wait) & ~inst_data_ok;
        end else if (div_start) begin
            st_d   = DIV;
            dcnt_d = DCNT_INIT;
        end else if (st_q == DIV) begin
            dcnt_d = dcnt_q - 8'd1;
            if (div_last) begin
                st_d = RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st_q   <= RUN;
            dcnt_q <= 8'd0;
            disc_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            dcnt_q <= dcnt_d;
            disc_q <= disc_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] pstall_q, pstall_d;
    logic [31:0] pflush_q, pflush_d;

    always_comb begin
        pstall_d = pstall_q + {31'd0, stall_pc};
        pflush_d = pflush_q + {31'd0, exc};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pstall_q <= 32'd0;
            pflush_q <= 32'd0;
        end else begin
            pstall_q <= pstall_d;
            pflush_q <= pflush_d;
        end
    end

    assign perf_stall_cnt = pstall_q;
    assign perf_flush_cnt = pflush_q;
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: cycle-level rule model plus directed scenarios with literal pins.
module tb_pipe_ctrl;

    localparam int DC = 33;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        mem_exc = 1'b0, mem_eret = 1'b0, data_wait = 1'b0;
    logic        ex_div_start = 1'b0, id_load_use = 1'b0;
    logic        inst_wait = 1'b0, inst_data_ok = 1'b0;
    logic        stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
    logic        flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb;
    logic        ex_div_done, if_discard;
    logic [31:0] perf_stall_cnt, perf_flush_cnt;

    pipe_ctrl #(.DIV_CYCLES(DC)) dut (
        .clk(clk), .resetn(resetn),
        .mem_exc(mem_exc), .mem_eret(mem_eret), .data_wait(data_wait),
        .ex_div_start(ex_div_start), .id_load_use(id_load_use),
        .inst_wait(inst_wait), .inst_data_ok(inst_data_ok),
        .stall_pc(stall_pc), .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
        .stall_ex_mem(stall_ex_mem), .stall_mem_wb(stall_mem_wb),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .flush_ex_mem(flush_ex_mem), .flush_mem_wb(flush_mem_wb),
        .ex_div_done(ex_div_done), .if_discard(if_discard),
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [4:0] stalls();
        return {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb};
    endfunction

    function automatic logic [3:0] flushes();
        return {flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb};
    endfunction

    // Model state: divide in flight with its completion cycle, pending discard, event counts.
    bit          m_div = 0;
    int          m_div_end = 0;
    bit          m_disc = 0;
    logic [31:0] m_pst = 0, m_pfl = 0;
    bit          e_exc, e_start, e_done, e_hold;
    logic [4:0]  es;
    logic [3:0]  ef;

    int n_done = 0, last_done = -1, n_fem = 0, n_spc = 0, n_disc = 0;

    always @(negedge clk) begin
        if (!resetn) begin
            m_div  = 0;
            m_disc = 0;
            m_pst  = 0;
            m_pfl  = 0;
            chk("reset_outs", {stalls(), flushes(), ex_div_done, if_discard}, 0);
            chk("reset_perf", {perf_stall_cnt, perf_flush_cnt}, 0);
        end else begin
            e_exc   = mem_exc || mem_eret;
            e_start = !m_div && ex_div_start && !e_exc && !data_wait;
            e_done  = m_div && (cyc == m_div_end) && !e_exc;
            e_hold  = (m_div && cyc < m_div_end) || e_start;
            if (e_exc) begin
                es = 5'b00000; ef = 4'b1111;
            end else if (data_wait) begin
                es = 5'b11110; ef = 4'b0001;
            end else if (e_hold) begin
                es = 5'b11100; ef = 4'b0010;
            end else if (id_load_use || inst_wait || m_disc) begin
                es = 5'b11000; ef = 4'b0100;
            end else begin
                es = 5'b00000; ef = 4'b0000;
            end
            chk("stalls", stalls(), es);
            chk("flushes", flushes(), ef);
            chk("div_done", ex_div_done, e_done);
            chk("if_discard", if_discard, m_disc && inst_data_ok);
            chk("no_stall_and_flush", stalls() & {1'b0, flushes()}, 0);
`ifdef PIPE_CTRL_PERF_EN
            chk("perf_stall", perf_stall_cnt, m_pst);
            chk("perf_flush", perf_flush_cnt, m_pfl);
`else
            chk("perf_tied", {perf_stall_cnt, perf_flush_cnt}, 0);
`endif
            if (es[4]) m_pst++;
            if (e_exc) m_pfl++;
            if (e_exc) begin
                m_div  = 0;
                m_disc = (m_disc || inst_wait) && !inst_data_ok;
            end else begin
                if (e_start) begin
                    m_div     = 1;
                    m_div_end = cyc + DC - 1;
                end else if (m_div && cyc == m_div_end) begin
                    m_div = 0;
                end
                m_disc = m_disc && !inst_data_ok;
            end
            if (ex_div_done) begin n_done++; last_done = cyc; end
            if (flush_ex_mem) n_fem++;
            if (stall_pc) n_spc++;
            if (if_discard) n_disc++;
        end
    end

    task automatic setin(input logic exc, eret, dw, ds, lu, iw, ok);
        mem_exc = exc; mem_eret = eret; data_wait = dw; ex_div_start = ds;
        id_load_use = lu; inst_wait = iw; inst_data_ok = ok;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        setin(0, 0, 0, 0, 0, 0, 0);
        repeat (n) step();
    endtask

    int t0, sp0, fe0, dn0, ds0;

    initial begin
        #1;
        chk("reset_outs_t0", {stalls(), flushes(), ex_div_done, if_discard}, 0);
        repeat (2) @(posedge clk);
        #2 resetn = 1'b1;
        step();
        idle(2);

        // Load-use for one cycle
        setin(0, 0, 0, 0, 1, 0, 0);
        #2;
        chk("lu_stalls", stalls(), 5'b11000);
        chk("lu_flushes", flushes(), 4'b0100);
        step();
        idle(1);
        #2 chk("lu_after", {stalls(), flushes()}, 0);
        idle(1);

        // Full divide
        t0 = cyc; fe0 = n_fem; dn0 = n_done;
        setin(0, 0, 0, 1, 0, 0, 0);
        #2 chk("div_start_fem", flush_ex_mem, 1'b1);
        step();
        idle(40);
        chk("div_done_cycle", last_done - t0, 32);
        chk("div_done_count", n_done - dn0, 1);
        chk("div_fem_cycles", n_fem - fe0, 32);

        // Exception aborts a divide
        t0 = cyc; dn0 = n_done;
        setin(0, 0, 0, 1, 0, 0, 0);
        step();
        idle(9);
        setin(1, 0, 0, 0, 0, 0, 0);
        #2 chk("exc_div_flush", {stalls(), flushes()}, 9'b00000_1111);
        step();
        sp0 = n_spc;
        idle(40);
        chk("exc_div_no_done", n_done - dn0, 0);
        chk("exc_div_no_stall", n_spc - sp0, 0);

        // Discard after redirect
        sp0 = n_spc; ds0 = n_disc;
        setin(1, 0, 0, 0, 0, 1, 0);
        step();
        idle(2);
        setin(0, 0, 0, 0, 0, 0, 1);
        #2 chk("disc_pulse", if_discard, 1'b1);
        step();
        idle(3);
        chk("disc_stall_cycles", n_spc - sp0, 3);
        chk("disc_count", n_disc - ds0, 1);

        // eret with response in the same cycle: nothing to discard
        setin(0, 1, 0, 0, 0, 1, 1);
        step();
        idle(1);
        #2 chk("eret_ok_no_disc", stall_pc, 1'b0);
        idle(1);

        // Exception while a discard is pending keeps it pending
        setin(1, 0, 0, 0, 0, 1, 0);
        step();
        setin(1, 0, 0, 0, 0, 0, 0);
        step();
        idle(2);
        #2 chk("disc_kept", stall_pc, 1'b1);
        setin(0, 0, 0, 0, 0, 0, 1);
        step();
        idle(2);

        // Priority: data wait over load-use and fetch wait
        setin(0, 0, 1, 0, 1, 1, 0);
        #2 chk("prio_dw", {stalls(), flushes()}, 9'b11110_0001);
        step();
        idle(2);

        // Divide start deferred by data wait, and data wait during divide
        setin(0, 0, 1, 1, 0, 0, 0);
        repeat (2) step();
        setin(0, 0, 0, 1, 0, 0, 0);
        step();
        setin(0, 0, 0, 0, 0, 0, 0);
        repeat (5) step();
        setin(0, 0, 1, 0, 0, 0, 0);
        repeat (3) step();
        idle(35);

        // Pseudo-random mix against the model
        for (int i = 0; i < 400; i++) begin
            setin($urandom_range(15) == 0, $urandom_range(31) == 0,
                  $urandom_range(3) == 0, $urandom_range(7) == 0,
                  $urandom_range(5) == 0, $urandom_range(2) == 0,
                  $urandom_range(2) == 0);
            step();
        end
        idle(40);

        // Asynchronous reset mid-divide with dcnt at 12
        setin(0, 0, 0, 1, 0, 0, 0);
        step();
        setin(0, 0, 0, 0, 0, 1, 0);
        repeat (20) step();
        #2 chk("pre_reset_fem", flush_ex_mem, 1'b1);
        resetn = 1'b0;
        #1;
        chk("async_reset_outs", {stalls(), flushes(), ex_div_done, if_discard}, 0);
        chk("async_reset_perf", {perf_stall_cnt, perf_flush_cnt}, 0);
        repeat (2) @(posedge clk);
        #2 resetn = 1'b1;
        setin(0, 0, 0, 0, 0, 0, 0);
        step();
        #2 chk("post_reset_idle", {stalls(), flushes(), ex_div_done}, 0);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
